// File: rtl/direction_controller_if.sv
// Bundle of the direction controller's pushbutton, tick and heading signals.
// master: whatever drives the buttons and game tick (board wrapper / bench).
// slave : the direction controller itself.
// Handshake: step_tick is a single-cycle strobe, sampled on the rising clock
// edge, with no ready/back-pressure; every output is registered, so a
// consumer may sample it at any time after the edge that updated it.
interface direction_controller_if;
  logic       up_pb;
  logic       down_pb;
  logic       right_pb;
  logic       left_pb;
  logic       step_tick;
  logic       out_up;
  logic       out_down;
  logic       out_right;
  logic       out_left;
  logic [1:0] dir_code;
  logic       dir_changed;
  logic       pending_valid;
  logic [1:0] pend_dir;      // observability of the pending request

  modport master (
    output up_pb, down_pb, right_pb, left_pb, step_tick,
    input  out_up, out_down, out_right, out_left, dir_code,
           dir_changed, pending_valid, pend_dir
  );

  modport slave (
    input  up_pb, down_pb, right_pb, left_pb, step_tick,
    output out_up, out_down, out_right, out_left, dir_code,
           dir_changed, pending_valid, pend_dir
  );
endinterface

// File: rtl/direction_controller.sv
// direction_controller: synchronises and debounces four direction buttons,
// picks one press per cycle by fixed priority (up > down > right > left),
// holds a single pending request and commits it on the game step tick.
// Heading encoding: 0 up, 1 down, 2 right, 3 left.
// Optional feature macro: REVERSE_BLOCK_EN -- when defined, a pending request
// that is the 180-degree reverse of the current heading is discarded at commit.
module direction_controller #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [1:0] INIT_DIR        = 2'd2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  direction_controller_if.slave  bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    INIT_OH  = 4'b0001 << INIT_DIR;

  // Button vector indexed by heading code.
  logic [3:0] raw_pb;
  assign raw_pb = {bus.left_pb, bus.right_pb, bus.down_pb, bus.up_pb};

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_prev_q;
  logic [3:0]    event_q;
  logic [CW-1:0] cnt_q [4];

  // Two-flop synchroniser on every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_pb;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples; the final one flips the
  // debounced state. Any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Registered one-cycle press events on debounced rising edges only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev_q <= '0;
      event_q    <= '0;
    end else begin
      deb_prev_q <= deb_q;
      event_q    <= deb_q & ~deb_prev_q;
    end
  end

  // Fixed-priority pick among this cycle's press events.
  logic       win_valid;
  logic [1:0] win_dir;
  always_comb begin
    win_valid = |event_q;
    win_dir   = 2'd3;
    if      (event_q[0]) win_dir = 2'd0;
    else if (event_q[1]) win_dir = 2'd1;
    else if (event_q[2]) win_dir = 2'd2;
  end

  logic [1:0] dir_q, dir_d;
  logic [3:0] oh_q;
  logic       changed_q, changed_d;
  logic       pv_q, pv_d;
  logic [1:0] pend_q, pend_d;
  logic       reverse_req;
  logic       accept;

  // A reverse request flips only the low bit of the code (up/down, right/left).
  assign reverse_req = (pend_q == (dir_q ^ 2'b01));

  // Commit decision and pending-register update. The tick consumes the old
  // pending value; a press in the same cycle then refills it.
  always_comb begin
`ifdef REVERSE_BLOCK_EN
    accept = bus.step_tick && pv_q && (pend_q != dir_q) && !reverse_req;
`else
    accept = bus.step_tick && pv_q && (pend_q != dir_q);
`endif
    dir_d     = accept ? pend_q : dir_q;
    changed_d = accept;
    pend_d    = win_valid ? win_dir : pend_q;
    pv_d      = pv_q;
    if (bus.step_tick) pv_d = 1'b0;
    if (win_valid)     pv_d = 1'b1;
  end

  // Heading, one-hot outputs, change pulse and pending request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q     <= INIT_DIR;
      oh_q      <= INIT_OH;
      changed_q <= 1'b0;
      pv_q      <= 1'b0;
      pend_q    <= '0;
    end else begin
      dir_q     <= dir_d;
      oh_q      <= 4'b0001 << dir_d;
      changed_q <= changed_d;
      pv_q      <= pv_d;
      pend_q    <= pend_d;
    end
  end

  assign bus.out_up        = oh_q[0];
  assign bus.out_down      = oh_q[1];
  assign bus.out_right     = oh_q[2];
  assign bus.out_left      = oh_q[3];
  assign bus.dir_code      = dir_q;
  assign bus.dir_changed   = changed_q;
  assign bus.pending_valid = pv_q;
  assign bus.pend_dir      = pend_q;

  // The reverse comparison is only consulted when the blocking feature is on.
  logic unused_ok;
  assign unused_ok = reverse_req;

endmodule

// File: tb/tb_direction_controller.sv
// Directed bench for direction_controller (DEBOUNCE_CYCLES = 4, INIT_DIR = 2).
// A small heading model predicts every commit; predictions are queued when a
// tick is driven and popped when the DUT's post-edge outputs are checked.
module tb_direction_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  direction_controller_if bus();

  direction_controller #(.DEBOUNCE_CYCLES(4), .INIT_DIR(2'd2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef REVERSE_BLOCK_EN
  localparam bit REV_BLOCK = 1'b1;
`else
  localparam bit REV_BLOCK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];     // {dir_changed, dir_code}
  logic [1:0] m_dir;
  logic [1:0] m_pend;
  logic       m_pv;

  logic [3:0] outs;
  assign outs = {bus.out_left, bus.out_right, bus.out_down, bus.out_up};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: bus.up_pb    = v;
      1: bus.down_pb  = v;
      2: bus.right_pb = v;
      default: bus.left_pb = v;
    endcase
  endtask

  // Press and hold a button; pending must appear exactly 8 edges later.
  task automatic press(input int idx, input string tag);
    set_btn(idx, 1'b1);
    edges(7);
    chk({tag, "_pv_early"}, 8'(bus.pending_valid), 8'(m_pv));
    edges(1);
    m_pend = 2'(idx);
    m_pv   = 1'b1;
    chk({tag, "_pv"},   8'(bus.pending_valid), 8'd1);
    chk({tag, "_pend"}, 8'(bus.pend_dir),      8'(m_pend));
    set_btn(idx, 1'b0);
    edges(8);
  endtask

  // Model one commit and push its expected result.
  task automatic predict_tick();
    logic chg;
    chg = m_pv && (m_pend != m_dir) && !(REV_BLOCK && (m_pend == (m_dir ^ 2'b01)));
    if (chg) m_dir = m_pend;
    m_pv = 1'b0;
    exp_q.push_back({chg, m_dir});
  endtask

  task automatic check_commit(input string tag);
    logic [2:0] e;
    e = exp_q.pop_front();
    chk({tag, "_code"},    8'(bus.dir_code),    8'(e[1:0]));
    chk({tag, "_onehot"},  8'(outs),            8'(4'b0001 << e[1:0]));
    chk({tag, "_changed"}, 8'(bus.dir_changed), 8'(e[2]));
  endtask

  task automatic do_tick(input string tag);
    predict_tick();
    bus.step_tick = 1'b1;
    edges(1);
    bus.step_tick = 1'b0;
    check_commit(tag);
    chk({tag, "_pv_clr"}, 8'(bus.pending_valid), 8'd0);
    edges(1);
    chk({tag, "_chg_fall"}, 8'(bus.dir_changed), 8'd0);
    chk({tag, "_hold"},     8'(bus.dir_code),    8'(m_dir));
  endtask

  task automatic model_reset();
    m_dir  = 2'd2;
    m_pend = 2'd0;
    m_pv   = 1'b0;
  endtask

  initial begin
    bus.up_pb = 0; bus.down_pb = 0; bus.right_pb = 0; bus.left_pb = 0;
    bus.step_tick = 0;
    rst_n = 1'b1;
    model_reset();

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    edges(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_onehot",  8'(outs),              8'h04);
    chk("rst_code",    8'(bus.dir_code),      8'd2);
    chk("rst_pv",      8'(bus.pending_valid), 8'd0);
    chk("rst_changed", 8'(bus.dir_changed),   8'd0);
    edges(2);
    rst_n = 1'b1;

    // Reset pulse while up is mid-debounce discards the press.
    bus.up_pb = 1'b1;
    edges(6);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.up_pb = 1'b0;
    model_reset();
    edges(10);
    chk("rst_mid_pv",   8'(bus.pending_valid), 8'd0);
    chk("rst_mid_code", 8'(bus.dir_code),      8'd2);

    // Press up from before edge 1, tick sampled at edge 10.
    bus.up_pb = 1'b1;
    edges(7);
    chk("pc_pv_e7", 8'(bus.pending_valid), 8'd0);
    edges(1);
    m_pend = 2'd0;
    m_pv   = 1'b1;
    chk("pc_pv_e8",   8'(bus.pending_valid), 8'd1);
    chk("pc_pend_e8", 8'(bus.pend_dir),      8'd0);
    bus.up_pb = 1'b0;
    edges(1);
    do_tick("pc_tick");
    edges(8);

    // Back to right, then request the reverse (left).
    press(2, "to_right");
    do_tick("to_right_tick");
    press(3, "rev_left");
    do_tick("rev_tick");

    // Down and left in the same cycle: down wins; a later up overwrites it.
    bus.down_pb = 1'b1;
    bus.left_pb = 1'b1;
    edges(8);
    m_pend = 2'd1;
    m_pv   = 1'b1;
    chk("prio_pv",   8'(bus.pending_valid), 8'd1);
    chk("prio_pend", 8'(bus.pend_dir),      8'd1);
    bus.down_pb = 1'b0;
    bus.left_pb = 1'b0;
    edges(8);
    press(0, "ovr_up");
    do_tick("ovr_tick");

    // Bouncing right button: 3-cycle pulses never survive debounce.
    for (int r = 0; r < 5; r++) begin
      bus.right_pb = 1'b1;
      for (int c = 0; c < 3; c++) begin
        edges(1);
        chk("bounce_pv", 8'(bus.pending_valid), 8'd0);
      end
      bus.right_pb = 1'b0;
      for (int c = 0; c < 2; c++) begin
        edges(1);
        chk("bounce_pv", 8'(bus.pending_valid), 8'd0);
      end
    end
    edges(10);
    chk("bounce_end_pv", 8'(bus.pending_valid), 8'd0);

    // Heading right, pending down; up's press event lands on the tick edge.
    press(2, "sc_right");
    do_tick("sc_right_tick");
    press(1, "sc_down");
    bus.up_pb = 1'b1;
    edges(7);
    predict_tick();
    bus.step_tick = 1'b1;
    edges(1);
    bus.step_tick = 1'b0;
    check_commit("sc_tick");
    m_pend = 2'd0;
    m_pv   = 1'b1;
    chk("sc_pv",   8'(bus.pending_valid), 8'd1);
    chk("sc_pend", 8'(bus.pend_dir),      8'd0);
    bus.up_pb = 1'b0;
    edges(8);
    do_tick("sc_up_tick");

    // Tick with nothing pending leaves the heading alone.
    do_tick("idle_tick");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_left observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/direction_controller.md
# direction_controller

Sequences the snake's heading for the game core. Takes the four raw direction pushbuttons, synchronises and debounces them, resolves simultaneous presses, holds at most one pending request, and commits it only on the game-step tick. Drives the one-hot heading consumed by the snake movement logic.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed to change a debounced button state; legal values are 2 to 2^20.
- INIT_DIR, 2'd2: heading loaded at reset. Encoding is 0 up, 1 down, 2 right, 3 left.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- up_pb / down_pb / right_pb / left_pb  in  1 each  raw, asynchronous, bouncy pushbuttons; active high.
- step_tick  in  1  one-cycle pulse from the game timer that commits the pending request.
- out_up / out_down / out_right / out_left  out  1 each  registered one-hot current heading.
- dir_code  out  2  registered encoded current heading.
- dir_changed  out  1  one-cycle pulse asserted in the cycle after a commit that changed the heading.
- pending_valid  out  1  high while a request is waiting for the next tick.

## Operation
- **Per-button front end**
  - Two-flop synchroniser, then a debouncer.
  - Debouncer: a counter increments while the synchronised value differs from the debounced state and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state takes the synchronised value and the counter clears.
  - A debounced 0→1 transition produces a one-cycle press event. Release produces no event.
- **Arbitration**
  - Simultaneous press events are resolved by fixed priority: up > down > right > left. Lower-priority events in the same cycle are dropped.
- **Pending register (pend_dir, pending_valid)**
  - The winning event overwrites pend_dir and sets pending_valid. The last accepted press wins.
- **Commit on step_tick**
  - If pending_valid is set, pend_dir is compared with the current heading.
  - Equal heading: no change, dir_changed stays 0.
  - Different heading: the heading and outputs update and dir_changed pulses.
  - pending_valid clears on every tick, whether or not the heading changed.
- **Tick and press in the same cycle**
  - The tick commits the old pending value.
  - The new event then becomes the pending value, so pending_valid = 1 after that edge.
- **Reset**
  - Every register clears immediately, including mid-debounce and mid-pending.
  - Outputs take INIT_DIR one-hot: out_right = 1 and the others 0 for the default.
  - dir_code = INIT_DIR, dir_changed = 0, pending_valid = 0.
  - All debounced states = 0 and all counters = 0.
  - A button held through reset release must satisfy the full debounce again before it produces an event.

## Timing
- Raw press, stable from before edge 1, with no overflow of the counter:
  - debounced rises at edge 2+DEBOUNCE_CYCLES;
  - the press event is registered at edge 3+DEBOUNCE_CYCLES;
  - pending_valid is high after edge 4+DEBOUNCE_CYCLES.
- Commit: a tick sampled at edge N updates the heading outputs, dir_code and dir_changed after edge N. dir_changed falls after edge N+1.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- Outputs are always exactly one-hot; there is never an all-zero or multi-hot cycle.

## Configuration
- REVERSE_BLOCK_EN, when defined:
  - a pending request that is the 180° reverse of the current heading is discarded at commit (up↔down, right↔left);
  - no heading change, no dir_changed, and pending_valid still clears.
- REVERSE_BLOCK_EN, when undefined: reversals commit like any other change.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset:** assert rst_n = 0 mid-cycle → outputs go immediately to out_right = 1, dir_code = 2, pending_valid = 0, dir_changed = 0. Press up, then pulse rst_n low before pending → after release, pending_valid = 0.
- **Press and commit:** hold up_pb from before edge 1 → pending_valid = 1 after edge 8. Tick at edge 10 → out_up = 1 and dir_code = 0 after edge 10, dir_changed high for exactly one cycle.
- **Reversal:** from heading right, press left, then tick.
  - With REVERSE_BLOCK_EN defined: heading stays right, dir_changed = 0, pending_valid = 0.
  - With REVERSE_BLOCK_EN undefined: dir_code = 3.
- **Priority and overwrite:** assert down_pb and left_pb in the same cycle → pend_dir = down. Then press up before the tick → the commit gives up.
- **Bounce:** pulse right_pb for 3 cycles, repeated 5 times with 2-cycle gaps → pending_valid never rises.
- **Same-cycle tick and press:** pending = down while heading is right. Up's press event occurs in the same cycle as the tick → heading becomes down, and after that edge pending_valid = 1 with pend_dir = up.
